// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 5-stage pipelined core. Owns the program
//   counter, addresses the combinational instruction memory and registers the
//   returned word together with its PC+4 into the IF/ID pipeline register.
//   Stall, flush and control-transfer redirects come from later stages.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   imem_addr      out  byte address to instruction memory (always == pc)
//   imem_instr     in   instruction word returned combinationally
//   stall          in   hold PC and IF/ID
//   flush          in   replace IF/ID with a bubble
//   pc_src         in   00 seq, 01 branch_target, 10 jump_target, 11 jr_target
//   branch_target  in   taken-branch target
//   jump_target    in   J/CLL target
//   jr_target      in   JR register value
//   pc             out  current fetch PC
//   if_id_instr    out  registered instruction
//   if_id_pc_plus4 out  registered PC+4 of that instruction (link value)
//   if_id_valid    out  IF/ID holds a real instruction
//   dbg_state_o    out  FSM state (0 = RESET_S, 1 = RUN)
//
// Optional build macro FETCH_PERF_CNT_EN adds:
//   fetch_count    out  cycles in which IF/ID loaded a valid word
//   stall_count    out  cycles with stall=1 and flush=0
//   flush_count    out  cycles with flush=1
//
// Handshake: there is no valid/ready pair here. stall is a level hold request
// from the hazard unit; flush and pc_src are single-cycle commands sampled on
// the rising edge. A redirect (pc_src != 00) always moves the PC, even under
// stall; flush always bubbles IF/ID, even under stall.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        dbg_state_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic {
    RESET_S = 1'b0,
    RUN     = 1'b1
  } state_e;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pp4_q, pp4_d;
  logic        valid_q, valid_d;
  logic [31:0] seq_pc;
  logic        load_ifid;

  // Sequential next PC; wraps naturally at 2^32.
  assign seq_pc    = pc_q + 32'd4;
  assign load_ifid = !flush && !stall;

  // Next-state logic for the non-reset case; reset is applied in always_ff.
  always_comb begin
    state_d = RUN;
    pc_d    = pc_q;
    instr_d = instr_q;
    pp4_d   = pp4_q;
    valid_d = valid_q;

    // PC: a redirect wins over stall.
    unique case (pc_src)
      2'b01:   pc_d = branch_target & ALIGN_MASK;
      2'b10:   pc_d = jump_target & ALIGN_MASK;
      2'b11:   pc_d = jr_target & ALIGN_MASK;
      default: pc_d = stall ? pc_q : seq_pc;
    endcase

    // IF/ID: flush wins over stall. Flush is never inferred from pc_src.
    if (flush) begin
      instr_d = NOP_INSTR;
      pp4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = imem_instr;
      pp4_d   = seq_pc;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_S;
      pc_q    <= RESET_PC & ALIGN_MASK;
      instr_q <= NOP_INSTR;
      pp4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp4_q   <= pp4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pp4_q;
  assign if_id_valid    = valid_q;
  assign dbg_state_o    = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (load_ifid)       fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall && !flush) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush)           flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  // Without the counters load_ifid has no consumer.
  logic unused_load_ifid;
  assign unused_load_ifid = load_ifid;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. Instruction memory is a pure function
//   of the address. A behavioural model tracks the architectural PC, the IF/ID
//   contents and the optional counters, one clock at a time, from the stage's
//   priority rules.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] imem_addr, imem_instr;
  logic        stall, flush;
  logic [1:0]  pc_src;
  logic [31:0] branch_target, jump_target, jr_target;
  logic [31:0] pc, if_id_instr, if_id_pc_plus4;
  logic        if_id_valid;
  logic        dbg_state_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count, flush_count;
`endif

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .flush          (flush),
    .pc_src         (pc_src),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .jr_target      (jr_target),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .dbg_state_o    (dbg_state_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
`endif
  );

  // Instruction memory contents: distinct, non-zero words per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_0000 ^ {a[7:0], 24'h000000};
  endfunction

  assign imem_instr = mem_word(imem_addr);

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid, m_run;
  logic [31:0] m_fc, m_sc, m_flc;

  // Driver: applies one cycle of inputs and advances the model across the edge.
  task automatic drive(input logic rst, input logic st, input logic fl,
                       input logic [1:0] src, input logic [31:0] bt,
                       input logic [31:0] jt, input logic [31:0] jr);
    logic [31:0] n_pc, n_instr, n_pp4;
    logic        n_valid;
    reset = rst; stall = st; flush = fl; pc_src = src;
    branch_target = bt; jump_target = jt; jr_target = jr;
    n_pc = m_pc; n_instr = m_instr; n_pp4 = m_pp4; n_valid = m_valid;
    if (rst) begin
      n_pc = {RESET_PC[31:2], 2'b00}; n_instr = NOP_INSTR; n_pp4 = 0; n_valid = 0;
      m_fc = 0; m_sc = 0; m_flc = 0;
    end else begin
      if (src == 2'd1)      n_pc = {bt[31:2], 2'b00};
      else if (src == 2'd2) n_pc = {jt[31:2], 2'b00};
      else if (src == 2'd3) n_pc = {jr[31:2], 2'b00};
      else if (!st)         n_pc = m_pc + 4;
      if (fl) begin
        n_instr = NOP_INSTR; n_pp4 = 0; n_valid = 0;
      end else if (!st) begin
        n_instr = mem_word(m_pc); n_pp4 = m_pc + 4; n_valid = 1;
      end
      if (!fl && !st) m_fc = m_fc + 1;
      if (st && !fl)  m_sc = m_sc + 1;
      if (fl)         m_flc = m_flc + 1;
    end
    m_run = !rst;
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pp4 = n_pp4; m_valid = n_valid;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want %h", imem_addr, 32'h0); end
    total++; if (if_id_instr !== NOP_INSTR) begin bad++; $display("FAIL reset_instr: got %h want %h", if_id_instr, NOP_INSTR); end
    total++; if (if_id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL reset_pp4: got %h want %h", if_id_pc_plus4, 32'h0); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
    total++; if (dbg_state_o !== 1'b0) begin bad++; $display("FAIL reset_state: got %b want 0", dbg_state_o); end
  endtask

  task automatic test_sequential();
    idle();
    total++; if (pc !== 32'h4) begin bad++; $display("FAIL seq_pc1: got %h want %h", pc, 32'h4); end
    total++; if (if_id_instr !== mem_word(32'h0)) begin bad++; $display("FAIL seq_instr1: got %h want %h", if_id_instr, mem_word(32'h0)); end
    total++; if (if_id_pc_plus4 !== 32'h4) begin bad++; $display("FAIL seq_pp4_1: got %h want %h", if_id_pc_plus4, 32'h4); end
    total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL seq_valid: got %b want 1", if_id_valid); end
    total++; if (dbg_state_o !== 1'b1) begin bad++; $display("FAIL seq_state: got %b want 1", dbg_state_o); end
    idle();
    total++; if (pc !== 32'h8) begin bad++; $display("FAIL seq_pc2: got %h want %h", pc, 32'h8); end
    total++; if (if_id_instr !== mem_word(32'h4)) begin bad++; $display("FAIL seq_instr2: got %h want %h", if_id_instr, mem_word(32'h4)); end
    total++; if (if_id_pc_plus4 !== 32'h8) begin bad++; $display("FAIL seq_pp4_2: got %h want %h", if_id_pc_plus4, 32'h8); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
      total++; if (pc !== 32'h8) begin bad++; $display("FAIL stall_pc[%0d]: got %h want %h", i, pc, 32'h8); end
      total++; if (if_id_instr !== mem_word(32'h4)) begin bad++; $display("FAIL stall_instr[%0d]: got %h want %h", i, if_id_instr, mem_word(32'h4)); end
      total++; if (if_id_pc_plus4 !== 32'h8) begin bad++; $display("FAIL stall_pp4[%0d]: got %h want %h", i, if_id_pc_plus4, 32'h8); end
    end
    idle();
    total++; if (pc !== 32'hC) begin bad++; $display("FAIL unstall_pc: got %h want %h", pc, 32'hC); end
    total++; if (if_id_instr !== mem_word(32'h8)) begin bad++; $display("FAIL unstall_instr: got %h want %h", if_id_instr, mem_word(32'h8)); end
  endtask

  task automatic test_branch_flush();
    drive(1'b0, 1'b0, 1'b1, 2'd2, 32'h0, 32'd40, 32'h0);
    total++; if (pc !== 32'd40) begin bad++; $display("FAIL jump40_pc: got %h want %h", pc, 32'd40); end
    drive(1'b0, 1'b0, 1'b1, 2'd1, 32'h0000_0033, 32'h0, 32'h0);
    total++; if (pc !== 32'h30) begin bad++; $display("FAIL br_pc: got %h want %h", pc, 32'h30); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL br_valid: got %b want 0", if_id_valid); end
    total++; if (if_id_instr !== NOP_INSTR) begin bad++; $display("FAIL br_instr: got %h want %h", if_id_instr, NOP_INSTR); end
    idle();
    total++; if (if_id_instr !== mem_word(32'h30)) begin bad++; $display("FAIL br_target_instr: got %h want %h", if_id_instr, mem_word(32'h30)); end
    total++; if (if_id_pc_plus4 !== 32'h34) begin bad++; $display("FAIL br_target_pp4: got %h want %h", if_id_pc_plus4, 32'h34); end
  endtask

  task automatic test_jr_over_stall();
    logic [31:0] held_instr, held_pp4;
    held_instr = mem_word(32'h30);
    held_pp4   = 32'h34;
    drive(1'b0, 1'b1, 1'b0, 2'd3, 32'h0, 32'h0, 32'h100);
    total++; if (pc !== 32'h100) begin bad++; $display("FAIL jr_pc: got %h want %h", pc, 32'h100); end
    total++; if (if_id_instr !== held_instr) begin bad++; $display("FAIL jr_held_instr: got %h want %h", if_id_instr, held_instr); end
    total++; if (if_id_pc_plus4 !== held_pp4) begin bad++; $display("FAIL jr_held_pp4: got %h want %h", if_id_pc_plus4, held_pp4); end
    total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL jr_held_valid: got %b want 1", if_id_valid); end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 1'b1, 2'd2, 32'h0, 32'hFFFF_FFFC, 32'h0);
    total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_load_pc: got %h want %h", pc, 32'hFFFF_FFFC); end
    idle();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc: got %h want %h", pc, 32'h0); end
    total++; if (if_id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_pp4: got %h want %h", if_id_pc_plus4, 32'h0); end
    total++; if (if_id_instr !== mem_word(32'hFFFF_FFFC)) begin bad++; $display("FAIL wrap_instr: got %h want %h", if_id_instr, mem_word(32'hFFFF_FFFC)); end
    // Unaligned target: low bits dropped on load, and without flush IF/ID captures normally.
    drive(1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0000_0207, 32'h0);
    total++; if (pc !== 32'h204) begin bad++; $display("FAIL align_pc: got %h want %h", pc, 32'h204); end
    total++; if (if_id_instr !== mem_word(32'h0)) begin bad++; $display("FAIL noflush_instr: got %h want %h", if_id_instr, mem_word(32'h0)); end
  endtask

  task automatic test_reset_mid();
    idle();
    drive(1'b1, 1'b1, 1'b0, 2'd2, 32'h0, 32'h0000_4000, 32'h0);
    total++; if (pc !== RESET_PC) begin bad++; $display("FAIL midrst_pc: got %h want %h", pc, RESET_PC); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", if_id_valid); end
    total++; if (dbg_state_o !== 1'b0) begin bad++; $display("FAIL midrst_state: got %b want 0", dbg_state_o); end
`ifdef FETCH_PERF_CNT_EN
    total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL midrst_fc: got %h want 0", fetch_count); end
    total++; if (stall_count !== 32'h0) begin bad++; $display("FAIL midrst_sc: got %h want 0", stall_count); end
    total++; if (flush_count !== 32'h0) begin bad++; $display("FAIL midrst_flc: got %h want 0", flush_count); end
`endif
  endtask

  task automatic test_random();
    logic        r, s, f;
    logic [1:0]  src;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 39) == 0);
      s   = ($urandom_range(0, 3) == 0);
      f   = ($urandom_range(0, 4) == 0);
      src = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      drive(r, s, f, src, $urandom, $urandom, $urandom);
      total++; if (pc !== m_pc || imem_addr !== m_pc) begin bad++; $display("FAIL rnd_pc[%0d]: got %h/%h want %h", i, pc, imem_addr, m_pc); end
      total++; if (if_id_instr !== m_instr) begin bad++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, if_id_instr, m_instr); end
      total++; if (if_id_pc_plus4 !== m_pp4) begin bad++; $display("FAIL rnd_pp4[%0d]: got %h want %h", i, if_id_pc_plus4, m_pp4); end
      total++; if (if_id_valid !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, if_id_valid, m_valid); end
      total++; if (dbg_state_o !== m_run) begin bad++; $display("FAIL rnd_state[%0d]: got %b want %b", i, dbg_state_o, m_run); end
`ifdef FETCH_PERF_CNT_EN
      total++; if (fetch_count !== m_fc) begin bad++; $display("FAIL rnd_fc[%0d]: got %h want %h", i, fetch_count, m_fc); end
      total++; if (stall_count !== m_sc) begin bad++; $display("FAIL rnd_sc[%0d]: got %h want %h", i, stall_count, m_sc); end
      total++; if (flush_count !== m_flc) begin bad++; $display("FAIL rnd_flc[%0d]: got %h want %h", i, flush_count, m_flc); end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; pc_src = 2'd0;
    branch_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;
    m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_run = 1'b0;
    m_fc = 32'h0; m_sc = 32'h0; m_flc = 32'h0;
    #2;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_flush();
    test_jr_over_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
